sha256_id_issue: RTL and testbench
==================================

Name: sha256_id_issue

Overview:
- Transmitter end of the ID stream consumed by the SHA-2 ID buffer (`id_in`/`id_in_last`/`id_in_valid`/`id_in_ready`).
- On each new message configuration accepted from the host/config register, it:
  - allocates a 6-bit message ID from a wrapping counter;
  - forks one beat to the message builder (config + ID) and one single-beat packet to the ID buffer.
- Limits in-flight messages with a credit counter returned by hash completion pulses.

Parameters:
- `ID_W`, 6, ID width; must match the ID buffer.
- `SIZE_W`, 64, message length field width (bits).
- `MAX_OUTSTANDING`, 4, maximum issued-but-not-completed messages (1..2^ID_W).
- `CNT_W`, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived).

Ports:
- `clk`  in  1  clock
- `nrst`  in  1  reset, asynchronous, active-low
- `en`  in  1  block enable; 0 freezes all state
- `sync_rst`  in  1  synchronous clear, effective only when `en`=1
- `cfg_size`  in  SIZE_W  message length of new message
- `cfg_valid`  in  1  config beat valid
- `cfg_ready`  out  1  config beat accepted
- `cfg_out_size`  out  SIZE_W  captured length to message builder
- `cfg_out_id`  out  ID_W  allocated ID to message builder
- `cfg_out_valid`  out  1  builder beat valid
- `cfg_out_ready`  in  1  builder ready
- `id_out`  out  ID_W  allocated ID to ID buffer
- `id_out_last`  out  1  packet last flag; constant 1 (single-beat packets)
- `id_out_valid`  out  1  ID beat valid
- `id_out_ready`  in  1  ID buffer ready
- `id_done`  in  1  one-cycle pulse: one message hash completed, returns one credit
- `status_id`  out  ID_W  last ID issued
- `status_outstanding`  out  CNT_W  current in-flight count

Behaviour:
- Reset (`nrst`=0, or `en`=1 with `sync_rst`=1):
  - all outputs and registers 0 except `id_out_last`=1;
  - `next_id`=0; state `IDLE`.
- `en`=0: no state change; outputs hold their values; `cfg_ready`=0.
- States: `IDLE`, `FORK`.
- `cfg_ready` = `en` & !`sync_rst` & (state==`IDLE`) & (`outstanding` < `MAX_OUTSTANDING`). Decoded from registers only; no combinational path from `cfg_valid`.
- Accept (`cfg_valid`&`cfg_ready`), registered into the next cycle:
  - `cfg_out_size`<=`cfg_size`; `cfg_out_id`<=`id_out`<=`status_id`<=`next_id`;
  - `cfg_out_valid`<=1; `id_out_valid`<=1;
  - `next_id`<=`next_id`+1 mod 2^ID_W (63 wraps to 0);
  - `outstanding`+=1; state->`FORK`.
  - Latency: accept edge to both valids high = 1 cycle.
- `FORK` handshakes:
  - each output independently drops its valid the cycle after its own handshake; data/valid stay stable until then.
  - When neither valid remains pending (both handshakes done, in any order or the same cycle), state->`IDLE`. `cfg_ready` is high on that next cycle if credit remains.
  - Maximum throughput: one message per 2 cycles.
- Credits:
  - `id_done` alone: `outstanding`-=1.
  - `id_done` in the same cycle as an accept: `outstanding` unchanged.
  - `id_done` with `outstanding`==0: ignored (no underflow).
- Full: `outstanding`==`MAX_OUTSTANDING` holds `cfg_ready`=0 until `id_done`; `cfg_ready` rises the cycle after the `id_done` pulse.
- `status_outstanding` mirrors the `outstanding` register.
- `sync_rst` mid-`FORK`: both valids drop next cycle, pending beats are discarded, IDs restart at 0.

Decomposition:
- Shared package `sha256_pkg`: `ID_W`, `SIZE_W`, `id_t`, `size_t` typedefs; state enum `id_issue_state_t`.
- No sub-module required.
- Credit counter may optionally be split out as `sha256_credit_cnt` (inc/dec/saturate at 0 and MAX) for reuse by the hash-out path.

Test Plan:
- **Basic issue:** reset, `cfg_size`=512 accepted, both readies held 1 -> next cycle `cfg_out_size`=512, `cfg_out_id`=0, `id_out`=0, `id_out_last`=1, `status_id`=0, `status_outstanding`=1; second config gets ID 1.
- **Skewed fork:** `id_out_ready`=0 for 5 cycles, `cfg_out_ready`=1 -> `cfg_out_valid` drops after 1 cycle, `id_out_valid`/`id_out` held stable 5 cycles, `cfg_ready` stays 0 until the ID handshake, then 1 on the following cycle.
- **Credit stall:** MAX_OUTSTANDING=4, issue 4 messages with no `id_done` -> `cfg_ready`=0 with `cfg_valid`=1 held; single `id_done` pulse -> `cfg_ready`=1 next cycle, 5th message gets ID 4; simultaneous accept+`id_done` keeps `status_outstanding` at 4.
- **ID wrap:** issue 65 messages with `id_done` returned after each -> IDs 0..63 then 0; `status_id` tracks each.
- **Underflow and enable:** `id_done` with `outstanding`=0 -> count stays 0. `en`=0 mid-`FORK` -> valids and data frozen, no handshake completes state change; `en`=1 resumes.
- **sync_rst mid-FORK:** `sync_rst`=1 while both valids high -> next cycle both valids 0, `status_outstanding`=0, next accepted message gets ID 0. Async `nrst` pulse mid-transfer gives the same result immediately.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 ID issue/buffer path.
package sha256_pkg;

   localparam int ID_W   = 6;
   localparam int SIZE_W = 64;

   typedef logic [ID_W-1:0]   id_t;
   typedef logic [SIZE_W-1:0] size_t;

   typedef enum logic {
      IDLE = 1'b0,
      FORK = 1'b1
   } id_issue_state_t;

endpackage

// File: rtl/sha256_credit_cnt.sv
// Up/down in-flight counter bounded to 0..MAX; a simultaneous inc and dec
// leaves the count unchanged.
module sha256_credit_cnt #(
   parameter int MAX   = 4,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             inc_ok;
   logic             dec_ok;

   // A decrement at zero is a stray pulse and is dropped; an increment at MAX
   // only lands if a decrement frees a slot in the same cycle.
   always_comb begin
      dec_ok   = dec && (cnt_reg != '0);
      inc_ok   = inc && ((cnt_reg != CNT_W'(MAX)) || dec_ok);
      cnt_next = cnt_reg;
      if (inc_ok && !dec_ok) begin
         cnt_next = cnt_reg + 1'b1;
      end else if (dec_ok && !inc_ok) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_reg <= '0;
      end else if (en) begin
         if (clr) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_next;
         end
      end
   end

   assign cnt  = cnt_reg;
   assign full = (cnt_reg == CNT_W'(MAX));

endmodule

// File: rtl/sha256_id_issue.sv
// Allocates message IDs and forks each accepted config into one builder beat
// and one single-beat ID packet, limited by in-flight credits.
module sha256_id_issue
   import sha256_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              en,
   input  logic              sync_rst,
   input  logic [SIZE_W-1:0] cfg_size,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [SIZE_W-1:0] cfg_out_size,
   output logic [ID_W-1:0]   cfg_out_id,
   output logic              cfg_out_valid,
   input  logic              cfg_out_ready,
   output logic [ID_W-1:0]   id_out,
   output logic              id_out_last,
   output logic              id_out_valid,
   input  logic              id_out_ready,
   input  logic              id_done,
   output logic [ID_W-1:0]   status_id,
   output logic [CNT_W-1:0]  status_outstanding
);

   id_issue_state_t state_reg;
   id_issue_state_t state_next;

   id_t   next_id_reg;
   id_t   issued_id_reg;
   size_t size_reg;
   logic  cfg_valid_reg;
   logic  id_valid_reg;

   logic  cfg_pend_next;
   logic  id_pend_next;
   logic  ready_int;
   logic  accept;
   logic  full;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= IDLE;
      end else if (en) begin
         state_reg <= sync_rst ? IDLE : state_next;
      end
   end

   // FORK ends once neither output still holds an unaccepted beat.
   always_comb begin
      cfg_pend_next = cfg_valid_reg && !cfg_out_ready;
      id_pend_next  = id_valid_reg && !id_out_ready;
      state_next    = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = FORK;
         FORK:    if (!cfg_pend_next && !id_pend_next) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready depends only on registers and the enable/clear controls, never on cfg_valid.
   always_comb begin
      ready_int = en && !sync_rst && (state_reg == IDLE) && !full;
   end

   assign accept = cfg_valid && ready_int;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         next_id_reg   <= '0;
         issued_id_reg <= '0;
         size_reg      <= '0;
         cfg_valid_reg <= 1'b0;
         id_valid_reg  <= 1'b0;
      end else if (en) begin
         if (sync_rst) begin
            next_id_reg   <= '0;
            issued_id_reg <= '0;
            size_reg      <= '0;
            cfg_valid_reg <= 1'b0;
            id_valid_reg  <= 1'b0;
         end else if (accept) begin
            next_id_reg   <= next_id_reg + 1'b1;
            issued_id_reg <= next_id_reg;
            size_reg      <= cfg_size;
            cfg_valid_reg <= 1'b1;
            id_valid_reg  <= 1'b1;
         end else begin
            cfg_valid_reg <= cfg_pend_next;
            id_valid_reg  <= id_pend_next;
         end
      end
   end

   sha256_credit_cnt #(
      .MAX   (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_credit (
      .clk  (clk),
      .nrst (nrst),
      .en   (en),
      .clr  (sync_rst),
      .inc  (accept),
      .dec  (id_done),
      .cnt  (status_outstanding),
      .full (full)
   );

   assign cfg_ready     = ready_int;
   assign cfg_out_size  = size_reg;
   assign cfg_out_id    = issued_id_reg;
   assign cfg_out_valid = cfg_valid_reg;
   assign id_out        = issued_id_reg;
   assign id_out_last   = 1'b1;
   assign id_out_valid  = id_valid_reg;
   assign status_id     = issued_id_reg;

endmodule

// File: tb/tb_sha256_id_issue.sv
// Bench for sha256_id_issue: fixed vector table, directed corner sequences and
// random traffic checked against a transaction-level model.
module tb_sha256_id_issue;
   import sha256_pkg::*;

   localparam int MAXO  = 4;
   localparam int CNT_W = $clog2(MAXO + 1);

   logic              clk = 1'b0;
   logic              nrst;
   logic              en;
   logic              sync_rst;
   logic [SIZE_W-1:0] cfg_size;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [SIZE_W-1:0] cfg_out_size;
   logic [ID_W-1:0]   cfg_out_id;
   logic              cfg_out_valid;
   logic              cfg_out_ready;
   logic [ID_W-1:0]   id_out;
   logic              id_out_last;
   logic              id_out_valid;
   logic              id_out_ready;
   logic              id_done;
   logic [ID_W-1:0]   status_id;
   logic [CNT_W-1:0]  status_outstanding;

   always #5 clk = ~clk;

   sha256_id_issue #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .nrst               (nrst),
      .en                 (en),
      .sync_rst           (sync_rst),
      .cfg_size           (cfg_size),
      .cfg_valid          (cfg_valid),
      .cfg_ready          (cfg_ready),
      .cfg_out_size       (cfg_out_size),
      .cfg_out_id         (cfg_out_id),
      .cfg_out_valid      (cfg_out_valid),
      .cfg_out_ready      (cfg_out_ready),
      .id_out             (id_out),
      .id_out_last        (id_out_last),
      .id_out_valid       (id_out_valid),
      .id_out_ready       (id_out_ready),
      .id_done            (id_done),
      .status_id          (status_id),
      .status_outstanding (status_outstanding)
   );

   int n_vec = 0;
   int n_err = 0;
   logic last_ready;

   // Model: the message currently being delivered plus the credit count.
   logic [63:0] m_size;
   int          m_id;
   int          m_next_id;
   int          m_outst;
   bit          m_cfg_v;
   bit          m_id_v;

   typedef struct {
      bit          v;
      logic [63:0] size;
      bit          cor;
      bit          ior;
      bit          done;
      bit          e_rdy;
      bit          e_cv;
      bit          e_iv;
      int          e_id;
      int          e_out;
      logic [63:0] e_size;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_size = '0; m_id = 0; m_next_id = 0; m_outst = 0; m_cfg_v = 0; m_id_v = 0;
   endtask

   function automatic bit m_ready(input bit e, input bit s);
      return e && !s && !(m_cfg_v || m_id_v) && (m_outst < MAXO);
   endfunction

   task automatic check_all();
      chk("cfg_out_size", cfg_out_size, m_size);
      chk("cfg_out_id", cfg_out_id, 64'(m_id));
      chk("cfg_out_valid", cfg_out_valid, 64'(m_cfg_v));
      chk("id_out", id_out, 64'(m_id));
      chk("id_out_last", id_out_last, 64'd1);
      chk("id_out_valid", id_out_valid, 64'(m_id_v));
      chk("status_id", status_id, 64'(m_id));
      chk("status_outstanding", status_outstanding, 64'(m_outst));
   endtask

   // One clock: drive just after the falling edge, check ready, advance the
   // model at the rising edge, check registered outputs at the next falling edge.
   task automatic cycle(input bit i_en, input bit i_srst, input bit i_v, input logic [63:0] i_size,
                        input bit i_cor, input bit i_ior, input bit i_done);
      bit rdy;
      bit acc;
      bit dec;
      en = i_en; sync_rst = i_srst; cfg_valid = i_v; cfg_size = i_size;
      cfg_out_ready = i_cor; id_out_ready = i_ior; id_done = i_done;
      #1;
      rdy = m_ready(i_en, i_srst);
      last_ready = cfg_ready;
      chk("cfg_ready", cfg_ready, 64'(rdy));
      @(posedge clk);
      if (i_en) begin
         if (i_srst) begin
            model_reset();
         end else begin
            acc = i_v && rdy;
            dec = i_done && (m_outst > 0);
            if (acc) begin
               m_size = i_size; m_id = m_next_id; m_next_id = (m_next_id + 1) % 64;
               m_cfg_v = 1; m_id_v = 1;
            end else begin
               if (i_cor) m_cfg_v = 0;
               if (i_ior) m_id_v = 0;
            end
            m_outst = m_outst + int'(acc) - int'(dec);
            if (acc) $display("issue id=%0d size=%0h outstanding=%0d", m_id, i_size, m_outst);
         end
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic issue(input logic [63:0] size, input bit done_on_fork);
      cycle(1, 0, 1, size, 1, 1, 0);
      cycle(1, 0, 0, 64'd0, 1, 1, done_on_fork);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && m_outst > 0; k++) cycle(1, 0, 0, 64'd0, 1, 1, 1);
   endtask

   initial begin
      nrst = 0; en = 0; sync_rst = 0; cfg_size = '0; cfg_valid = 0;
      cfg_out_ready = 0; id_out_ready = 0; id_done = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("reset_cfg_ready", cfg_ready, 64'd0);
      nrst = 1;

      //           v  size   cor ior done rdy cv iv id out size
      tbl[0] = '{1, 64'd512,  1, 1, 0,   1,  1, 1, 0, 1, 64'd512};
      tbl[1] = '{1, 64'd1000, 1, 1, 0,   0,  0, 0, 0, 1, 64'd512};
      tbl[2] = '{1, 64'd1000, 1, 1, 0,   1,  1, 1, 1, 2, 64'd1000};
      tbl[3] = '{0, 64'd0,    1, 0, 0,   0,  0, 1, 1, 2, 64'd1000};
      tbl[4] = '{0, 64'd0,    1, 0, 0,   0,  0, 1, 1, 2, 64'd1000};
      tbl[5] = '{0, 64'd0,    1, 1, 0,   0,  0, 0, 1, 2, 64'd1000};
      tbl[6] = '{0, 64'd0,    1, 1, 1,   1,  0, 0, 1, 1, 64'd1000};
      tbl[7] = '{0, 64'd0,    1, 1, 1,   1,  0, 0, 1, 0, 64'd1000};
      tbl[8] = '{0, 64'd0,    1, 1, 1,   1,  0, 0, 1, 0, 64'd1000};
      tbl[9] = '{1, 64'd7,    1, 1, 0,   1,  1, 1, 2, 1, 64'd7};
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, tbl[i].v, tbl[i].size, tbl[i].cor, tbl[i].ior, tbl[i].done);
         chk("tbl_ready", last_ready, 64'(tbl[i].e_rdy));
         chk("tbl_cfg_valid", cfg_out_valid, 64'(tbl[i].e_cv));
         chk("tbl_id_valid", id_out_valid, 64'(tbl[i].e_iv));
         chk("tbl_id", id_out, 64'(tbl[i].e_id));
         chk("tbl_outstanding", status_outstanding, 64'(tbl[i].e_out));
         chk("tbl_size", cfg_out_size, tbl[i].e_size);
      end
      cycle(1, 0, 0, 64'd0, 1, 1, 0);

      // Skewed fork: the ID side stalls for five cycles.
      cycle(1, 0, 1, 64'h40, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 1, 64'h99, 1, 0, 0);
         chk("skew_ready", last_ready, 64'd0);
         chk("skew_id_hold", id_out, 64'd3);
         chk("skew_cfg_drop", cfg_out_valid, 64'd0);
      end
      cycle(1, 0, 0, 64'd0, 1, 1, 0);
      chk("skew_id_done", id_out_valid, 64'd0);
      cycle(1, 0, 0, 64'd0, 1, 1, 0);
      chk("skew_ready_after", last_ready, 64'd1);

      // Credit stall at MAX outstanding.
      drain();
      for (int i = 0; i < 4; i++) issue(64'(100 + i), 0);
      chk("stall_outst", status_outstanding, 64'd4);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 1, 64'h55, 1, 1, 0);
         chk("stall_ready", last_ready, 64'd0);
      end
      cycle(1, 0, 1, 64'h55, 1, 1, 1);
      chk("stall_ready_pulse", last_ready, 64'd0);
      chk("stall_outst_dec", status_outstanding, 64'd3);
      cycle(1, 0, 1, 64'h55, 1, 1, 0);
      chk("stall_ready_back", last_ready, 64'd1);
      chk("stall_fifth_id", id_out, 64'd8);
      cycle(1, 0, 0, 64'd0, 1, 1, 1);
      chk("stall_outst_3", status_outstanding, 64'd3);
      cycle(1, 0, 1, 64'h66, 1, 1, 1);
      chk("acc_done_same", status_outstanding, 64'd3);
      cycle(1, 0, 0, 64'd0, 1, 1, 0);

      // ID wrap: restart numbering from 0 and issue 65 messages.
      cycle(1, 1, 0, 64'd0, 0, 0, 0);
      for (int i = 0; i < 65; i++) begin
         issue(64'(i * 3), 1);
         chk("wrap_id", status_id, 64'(i % 64));
         chk("wrap_outst", status_outstanding, 64'd0);
      end

      // Underflow, then enable freeze mid-FORK.
      cycle(1, 0, 0, 64'd0, 1, 1, 1);
      chk("underflow", status_outstanding, 64'd0);
      cycle(1, 0, 1, 64'h123, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 64'h77, 1, 1, 1);
         chk("freeze_cfg_valid", cfg_out_valid, 64'd1);
         chk("freeze_id_valid", id_out_valid, 64'd1);
         chk("freeze_ready", last_ready, 64'd0);
      end
      cycle(1, 0, 0, 64'd0, 1, 1, 0);
      chk("resume_valid", id_out_valid, 64'd0);

      // Synchronous clear mid-FORK.
      cycle(1, 0, 1, 64'h200, 0, 0, 0);
      cycle(1, 1, 0, 64'd0, 0, 0, 0);
      chk("srst_valids", {cfg_out_valid, id_out_valid}, 64'd0);
      chk("srst_outst", status_outstanding, 64'd0);
      issue(64'h300, 0);
      chk("srst_first_id", status_id, 64'd0);

      // Asynchronous reset mid-transfer.
      issue(64'h301, 0);
      cycle(1, 0, 1, 64'h302, 0, 0, 0);
      nrst = 0;
      #1;
      chk("nrst_valids", {cfg_out_valid, id_out_valid}, 64'd0);
      chk("nrst_id", status_id, 64'd0);
      chk("nrst_outst", status_outstanding, 64'd0);
      chk("nrst_size", cfg_out_size, 64'd0);
      chk("nrst_last", id_out_last, 64'd1);
      model_reset();
      #1;
      nrst = 1;
      issue(64'h303, 0);
      chk("nrst_first_id", status_id, 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bit r_done;
         r_done = (m_outst > 0) && ($urandom_range(0, 3) == 0);
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
               {$urandom, $urandom}, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, r_done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
